// File: rtl/writeback.sv
// Writeback stage: retires ALU results and formats load data into a registered regfile write port.
// Optional bypass ports are enabled by defining WRITEBACK_FWD_EN.
module writeback #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_dest_en,
    input  logic [ADDR_WIDTH-1:0] in_dest_addr,
    input  logic [WIDTH-1:0]      in_result,
    input  logic                  in_is_load,
    input  logic [1:0]            in_load_size,
    input  logic                  in_load_unsigned,
    input  logic [1:0]            in_addr_lsb,
    input  logic                  mem_rvalid,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  dest_en,
    output logic [ADDR_WIDTH-1:0] dest_addr,
    output logic [WIDTH-1:0]      dest_data,
    output logic                  misalign_err,
    output logic                  fwd0_valid,
    output logic [ADDR_WIDTH-1:0] fwd0_addr,
    output logic [WIDTH-1:0]      fwd0_data,
    output logic                  fwd1_valid,
    output logic [ADDR_WIDTH-1:0] fwd1_addr,
    output logic [WIDTH-1:0]      fwd1_data
);

    typedef enum logic {StIdle, StWaitLoad} state_t;

    state_t                r_state, w_state_next;
    logic                  r_dest_en, w_dest_en_next;
    logic [ADDR_WIDTH-1:0] r_dest_addr, w_dest_addr_next;
    logic [WIDTH-1:0]      r_dest_data, w_dest_data_next;
    logic                  r_misalign, w_misalign_next;
    logic                  r_ld_en, w_ld_en_next;
    logic [ADDR_WIDTH-1:0] r_ld_addr, w_ld_addr_next;
    logic [1:0]            r_ld_size, w_ld_size_next;
    logic                  r_ld_unsigned, w_ld_unsigned_next;
    logic [1:0]            r_ld_lsb, w_ld_lsb_next;

    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_wr_en;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [WIDTH-1:0]      w_load_data;

    assign in_ready = (r_state == StIdle) & ~rst;
    assign w_accept = in_valid & in_ready;
    assign w_wr_en  = in_dest_en & (in_dest_addr != '0);

    assign w_misalign = (in_load_size == 2'd3)
                      | ((in_load_size == 2'd1) & in_addr_lsb[0])
                      | ((in_load_size == 2'd2) & (in_addr_lsb != 2'd0));

    always_comb begin
        w_byte      = mem_rdata[{r_ld_lsb, 3'b000} +: 8];
        w_half      = mem_rdata[{r_ld_lsb[1], 4'b0000} +: 16];
        w_load_data = mem_rdata;
        case (r_ld_size)
            2'd0:    w_load_data = {{(WIDTH-8){~r_ld_unsigned & w_byte[7]}}, w_byte};
            2'd1:    w_load_data = {{(WIDTH-16){~r_ld_unsigned & w_half[15]}}, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_comb begin
        w_state_next       = r_state;
        w_dest_en_next     = 1'b0;
        w_dest_addr_next   = r_dest_addr;
        w_dest_data_next   = r_dest_data;
        w_misalign_next    = 1'b0;
        w_ld_en_next       = r_ld_en;
        w_ld_addr_next     = r_ld_addr;
        w_ld_size_next     = r_ld_size;
        w_ld_unsigned_next = r_ld_unsigned;
        w_ld_lsb_next      = r_ld_lsb;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (!in_is_load) begin
                        w_dest_en_next   = w_wr_en;
                        w_dest_addr_next = in_dest_addr;
                        w_dest_data_next = in_result;
                    end else if (w_misalign) begin
                        w_misalign_next = 1'b1;
                    end else begin
                        w_ld_en_next       = w_wr_en;
                        w_ld_addr_next     = in_dest_addr;
                        w_ld_size_next     = in_load_size;
                        w_ld_unsigned_next = in_load_unsigned;
                        w_ld_lsb_next      = in_addr_lsb;
                        w_state_next       = StWaitLoad;
                    end
                end
            end
            StWaitLoad: begin
                if (mem_rvalid) begin
                    w_dest_en_next   = r_ld_en;
                    w_dest_addr_next = r_ld_addr;
                    w_dest_data_next = w_load_data;
                    w_state_next     = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_dest_en     <= 1'b0;
            r_dest_addr   <= '0;
            r_dest_data   <= '0;
            r_misalign    <= 1'b0;
            r_ld_en       <= 1'b0;
            r_ld_addr     <= '0;
            r_ld_size     <= 2'd0;
            r_ld_unsigned <= 1'b0;
            r_ld_lsb      <= 2'd0;
        end else begin
            r_state       <= w_state_next;
            r_dest_en     <= w_dest_en_next;
            r_dest_addr   <= w_dest_addr_next;
            r_dest_data   <= w_dest_data_next;
            r_misalign    <= w_misalign_next;
            r_ld_en       <= w_ld_en_next;
            r_ld_addr     <= w_ld_addr_next;
            r_ld_size     <= w_ld_size_next;
            r_ld_unsigned <= w_ld_unsigned_next;
            r_ld_lsb      <= w_ld_lsb_next;
        end
    end

    assign dest_en      = r_dest_en;
    assign dest_addr    = r_dest_addr;
    assign dest_data    = r_dest_data;
    assign misalign_err = r_misalign;

`ifdef WRITEBACK_FWD_EN
    logic                  r_fwd1_valid;
    logic [ADDR_WIDTH-1:0] r_fwd1_addr;
    logic [WIDTH-1:0]      r_fwd1_data;

    // fwd1 delays the write port one cycle to cover the regfile read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd1_valid <= 1'b0;
            r_fwd1_addr  <= '0;
            r_fwd1_data  <= '0;
        end else begin
            r_fwd1_valid <= r_dest_en;
            r_fwd1_addr  <= r_dest_addr;
            r_fwd1_data  <= r_dest_data;
        end
    end

    assign fwd0_valid = r_dest_en;
    assign fwd0_addr  = r_dest_addr;
    assign fwd0_data  = r_dest_data;
    assign fwd1_valid = r_fwd1_valid;
    assign fwd1_addr  = r_fwd1_addr;
    assign fwd1_data  = r_fwd1_data;
`else
    assign fwd0_valid = 1'b0;
    assign fwd0_addr  = '0;
    assign fwd0_data  = '0;
    assign fwd1_valid = 1'b0;
    assign fwd1_addr  = '0;
    assign fwd1_data  = '0;
`endif

endmodule
